mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_step.sv | 34 +++
 rtl/mdu_sequencer.sv | 140 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// iteration count and the divide-by-zero result constant.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_t;

  localparam int          MDU_STEPS   = 32;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // Absolute value for signed ops; unsigned ops pass the value through.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on operand magnitudes.
// Multiply: shift-add, multiplier in acc_lo, partial product grows in acc_hi.
// Divide: restoring subtract, dividend shifts out of acc_lo, quotient bits
// shift into acc_lo, partial remainder lives in acc_hi.
module mdu_step (
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  input  logic [31:0] operand,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo
);

  logic [32:0] add_sum;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_sub;

  // Compute both the multiply and divide step and select by op class
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
    shifted = {acc_hi, acc_lo[31]};
    fits    = (shifted >= {1'b0, operand});
    rem_sub = shifted[31:0] - operand;
    if (is_div) begin
      next_hi = fits ? rem_sub : shifted[31:0];
      next_lo = {acc_lo[30:0], fits};
    end else begin
      next_hi = add_sum[32:1];
      next_lo = {add_sum[0], acc_lo[31:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative HI/LO multiply/divide unit: 32 CALC steps, one FIX cycle for sign
// correction, commit into hi/lo on entry to DONE. Owns every register.
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hilo_read,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state, next_state;
  logic [4:0]  count;
  logic        op_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] a_raw;
  logic [31:0] operand;
  logic [31:0] acc_hi, acc_lo;
  logic [31:0] step_hi, step_lo;
  logic [31:0] fix_hi, fix_lo;
  logic [63:0] product;
  logic        op_signed;

  assign op_signed = ~op[0];

  mdu_step u_step (
    .is_div  (op_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic and status outputs; cancel aborts any active state
  always_comb begin
    next_state = state;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    stall      = busy & (start | hilo_read | hi_we | lo_we);
    case (state)
      ST_IDLE: if (start && !cancel) next_state = ST_CALC;
      ST_CALC: if (count == 5'(MDU_STEPS - 1)) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    if (state != ST_IDLE && cancel) next_state = ST_IDLE;
  end

  // Sign correction of the raw magnitude result, with the divide-by-zero override
  always_comb begin
    product = {acc_hi, acc_lo};
    fix_hi  = acc_hi;
    fix_lo  = acc_lo;
    if (op_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = DIV_ZERO_LO;
      end else begin
        fix_hi = neg_rem ? (~acc_hi + 32'd1) : acc_hi;
        fix_lo = neg_res ? (~acc_lo + 32'd1) : acc_lo;
      end
    end else if (neg_res) begin
      {fix_hi, fix_lo} = ~product + 64'd1;
    end
  end

  // Operand latch, iteration datapath, and the architectural hi/lo registers
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      operand  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (start && !cancel) begin
            op_div   <= op[1];
            neg_res  <= op_signed & (a[31] ^ b[31]);
            neg_rem  <= op_signed & a[31];
            div_zero <= (b == 32'd0);
            a_raw    <= a;
            operand  <= magnitude(b, op_signed);
            acc_hi   <= '0;
            acc_lo   <= magnitude(a, op_signed);
          end
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
        ST_CALC: begin
          if (cancel) begin
            count <= '0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count + 5'd1;
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written cancel/stall/reset sequences.
module tb_mdu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        hilo_read;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  mdu_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .hilo_read (hilo_read),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Architectural result of one op, computed with plain wide arithmetic
  function automatic void ref_model(input logic [1:0] op_in, input logic [31:0] a_in, input logic [31:0] b_in,
                                    output logic [31:0] r_hi, output logic [31:0] r_lo);
    longint      sa, sb, ua, ub, q, r;
    logic [63:0] prod, qv, rv;
    sa = longint'($signed(a_in));
    sb = longint'($signed(b_in));
    ua = longint'({32'd0, a_in});
    ub = longint'({32'd0, b_in});
    r_hi = '0;
    r_lo = '0;
    if (op_in[1] && b_in == 32'd0) begin
      r_hi = a_in;
      r_lo = 32'hFFFF_FFFF;
    end else begin
      case (op_in)
        2'b00: begin prod = 64'(sa * sb); r_hi = prod[63:32]; r_lo = prod[31:0]; end
        2'b01: begin prod = {32'd0, a_in} * {32'd0, b_in}; r_hi = prod[63:32]; r_lo = prod[31:0]; end
        2'b10: begin q = sa / sb; r = sa % sb; qv = 64'(q); rv = 64'(r); r_hi = rv[31:0]; r_lo = qv[31:0]; end
        default: begin q = ua / ub; r = ua % ub; qv = 64'(q); rv = 64'(r); r_hi = rv[31:0]; r_lo = qv[31:0]; end
      endcase
    end
  endfunction

  // Wait for done with a cycle bound; returns cycles counted from the start cycle
  task automatic waitDone(input int first, output int cycles);
    cycles = first;
    while (!done && cycles < 100) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  // Issue one op from IDLE, then check latency, result and the single-cycle done
  task automatic applyStimulus(input logic [1:0] op_in, input logic [31:0] a_in, input logic [31:0] b_in,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    int cycles;
    op    = op_in;
    a     = a_in;
    b     = b_in;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    waitDone(1, cycles);
    checkOutput({name, " latency"}, 64'(cycles), 64'd34);
    checkOutput({name, " hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({name, " lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clock);
    checkOutput({name, " busy/done after DONE"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int          cycles, pulses;
    logic [31:0] eh, el, ra, rb;
    logic [1:0]  rop;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; cancel = 1'b0;
    hilo_read = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    checkOutput("reset busy/done/stall", {61'd0, busy, done, stall}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 9; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      ref_model(rop, ra, rb, eh, el);
      applyStimulus(rop, ra, rb, eh, el, $sformatf("rand%0d op%0d", i, rop));
    end

    // MTHI/MTLO and stall behaviour while idle; cancel is ignored in IDLE
    hi_we = 1'b1; wdata = 32'h0000_CAFE; hilo_read = 1'b1;
    #1 checkOutput("idle stall", 64'(stall), 64'd0);
    @(negedge clock);
    hi_we = 1'b0; hilo_read = 1'b0; lo_we = 1'b1; cancel = 1'b1; wdata = 32'h0000_BEEF;
    @(negedge clock);
    lo_we = 1'b0; cancel = 1'b0;
    checkOutput("mthi idle", 64'(hi), 64'h0000_CAFE);
    checkOutput("mtlo idle with cancel", 64'(lo), 64'h0000_BEEF);
    checkOutput("cancel in idle busy", 64'(busy), 64'd0);

    // Cancel at CALC cycle 10: hi/lo keep the previous result, no done
    applyStimulus(2'b01, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, "pre-cancel");
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    checkOutput("cancel busy", 64'(busy), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      @(negedge clock);
    end
    checkOutput("cancel no done", 64'(pulses), 64'd0);
    checkOutput("cancel hi kept", 64'(hi), 64'd3);
    checkOutput("cancel lo kept", 64'(lo), 64'd0);

    // Start while busy at cycle 12 is stalled and ignored
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    #1 checkOutput("stall on busy start", 64'(stall), 64'd1);
    @(negedge clock);
    start = 1'b0;
    hilo_read = 1'b1;
    #1 checkOutput("stall on busy hilo_read", 64'(stall), 64'd1);
    @(negedge clock);
    hilo_read = 1'b0;
    waitDone(14, cycles);
    checkOutput("ignored start latency", 64'(cycles), 64'd34);
    checkOutput("ignored start hi", 64'(hi), 64'd2);
    checkOutput("ignored start lo", 64'(lo), 64'd14);
    repeat (2) @(negedge clock);
    checkOutput("ignored start not queued", 64'(busy), 64'd0);

    // MTHI while busy is stalled and dropped; reset mid-CALC clears everything
    op = 2'b00; a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    #1 checkOutput("mthi busy stall", 64'(stall), 64'd1);
    @(negedge clock);
    hi_we = 1'b0;
    checkOutput("mthi busy hi unchanged", 64'(hi), 64'd2);
    repeat (17) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid-op reset hi/lo", {hi, lo}, 64'd0);
    checkOutput("mid-op reset busy/done/stall", {61'd0, busy, done, stall}, 64'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) pulses++;
      @(negedge clock);
    end
    checkOutput("mid-op reset quiet", 64'(pulses), 64'd0);

    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
